// File: rtl/ysyx_25020047_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// the default reset PC and the instruction alignment width.
package ysyx_25020047_pkg;

    // Fetch unit control states, 3-bit encoding
    typedef enum logic [2:0] {
        IFU_IDLE    = 3'd0,
        IFU_REQ     = 3'd1,
        IFU_RESP    = 3'd2,
        IFU_ISSUE   = 3'd3,
        IFU_WAIT_WB = 3'd4,
        IFU_FAULT   = 3'd5
    } ifu_state_e;

    // Architectural PC after reset
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // Number of low address bits that must be zero for a legal instruction address
    localparam int ALIGN_BITS = 2;

endpackage

// File: rtl/ysyx_25020047_ifu.sv
// Multi-cycle instruction fetch unit. Fetches one instruction from
// instruction memory, hands {inst, pc, snpc} to decode, then waits for
// write-back to return the next PC. Memory errors and misaligned next-PC
// values park the unit in a sticky fault state until reset.
module ysyx_25020047_ifu
    import ysyx_25020047_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            imem_resp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] snpc,
    output logic            wb_ready,
    input  logic            wb_valid,
    input  logic [XLEN-1:0] wb_dnpc,
    output logic            fault,
    output logic [XLEN-1:0] fault_pc,
    output logic [31:0]     fetch_cnt
);

    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;
    logic [31:0]     fetch_cnt_q, fetch_cnt_d;
    logic            dnpc_misaligned;

    assign dnpc_misaligned = (wb_dnpc[ALIGN_BITS-1:0] != '0);

    // State and datapath registers, asynchronously cleared to the reset PC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IFU_IDLE;
            pc_q        <= XLEN'(RESET_PC);
            inst_q      <= '0;
            fault_pc_q  <= '0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            fault_pc_q  <= fault_pc_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    // Next-state sequencing through request, response, issue and write-back wait
    always_comb begin
        state_d = state_q;
        case (state_q)
            IFU_IDLE:    state_d = IFU_REQ;
            IFU_REQ:     if (imem_req_ready) state_d = IFU_RESP;
            IFU_RESP: begin
                if (imem_resp_valid) begin
                    state_d = imem_resp_err ? IFU_FAULT : IFU_ISSUE;
                end
            end
            IFU_ISSUE:   if (inst_ready) state_d = IFU_WAIT_WB;
            IFU_WAIT_WB: begin
                if (wb_valid) begin
                    state_d = dnpc_misaligned ? IFU_FAULT : IFU_REQ;
                end
            end
            IFU_FAULT:   state_d = IFU_FAULT;
            default:     state_d = IFU_IDLE;
        endcase
    end

    // Datapath updates: capture instruction, redirect PC, record fault address, count issues
    always_comb begin
        pc_d        = pc_q;
        inst_d      = inst_q;
        fault_pc_d  = fault_pc_q;
        fetch_cnt_d = fetch_cnt_q;
        case (state_q)
            IFU_RESP: begin
                if (imem_resp_valid) begin
                    if (imem_resp_err) begin
                        fault_pc_d = pc_q;
                    end else begin
                        inst_d = imem_resp_data;
                    end
                end
            end
            IFU_ISSUE: begin
                if (inst_ready) begin
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                end
            end
            IFU_WAIT_WB: begin
                if (wb_valid) begin
                    if (dnpc_misaligned) begin
                        fault_pc_d = wb_dnpc;
                    end else begin
                        pc_d = wb_dnpc;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Outputs decoded purely from state and registers, no input-to-output paths
    always_comb begin
        imem_req_valid = (state_q == IFU_REQ);
        inst_valid     = (state_q == IFU_ISSUE);
        wb_ready       = (state_q == IFU_WAIT_WB);
        fault          = (state_q == IFU_FAULT);
        imem_req_addr  = pc_q;
        pc             = pc_q;
        snpc           = pc_q + XLEN'(4);
        inst           = inst_q;
        fault_pc       = fault_pc_q;
        fetch_cnt      = fetch_cnt_q;
    end

endmodule
